axis_fifo: RTL
==============

Name: axis_fifo

Overview:
Parametrised synchronous AXI4-Stream FIFO that carries the full beat: tdata, tkeep, tlast and tuser.
Widths follow the codebase stream convention: data width in bytes, user width in bits.
Sits between stream producers and consumers in the ethernet datapath, such as a MAC RX feeding a packet parser, to absorb backpressure.
Adds depth, occupancy reporting and an optional store-and-forward packet mode.

Parameters:
DATA_WIDTH, 1, tdata width in bytes; tkeep width equals DATA_WIDTH.
USER_WIDTH, 1, tuser width in bits.
DEPTH, 16, number of beat entries; power of two, 2 to 4096.

Ports:
clock  input  1  single clock for all logic
aresetn  input  1  asynchronous active-low reset
s_axis_tdata  input  DATA_WIDTH*8  write-side data
s_axis_tkeep  input  DATA_WIDTH  write-side byte enables
s_axis_tuser  input  USER_WIDTH  write-side sideband
s_axis_tlast  input  1  write-side end of packet
s_axis_tvalid  input  1  write-side valid
s_axis_tready  output  1  write-side ready
m_axis_tdata  output  DATA_WIDTH*8  read-side data
m_axis_tkeep  output  DATA_WIDTH  read-side byte enables
m_axis_tuser  output  USER_WIDTH  read-side sideband
m_axis_tlast  output  1  read-side end of packet
m_axis_tvalid  output  1  read-side valid
m_axis_tready  input  1  read-side ready
occupancy  output  $clog2(DEPTH+1)  beats currently stored

Behaviour:
- Reset (aresetn=0, asynchronous) clears:
  - wr_ptr, rd_ptr and commit_ptr to 0
  - occupancy to 0, m_axis_tvalid to 0 and s_axis_tready to 0
  - storage contents are don't-care.
- Reset asserted mid-packet discards all stored beats. No partial beat ever appears on m_axis after release.
- Pointers are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty; wrap is natural modulo 2*DEPTH.
  - full: pointer MSBs differ and the low bits are equal
  - empty: pointers are equal
- Write handshake: a beat is accepted on a rising edge with s_axis_tvalid && s_axis_tready. That edge stores {tdata,tkeep,tuser,tlast} at wr_ptr and increments wr_ptr.
- s_axis_tready is registered. It is 1 iff the next-state occupancy is below DEPTH.
  - It goes to 1 in the first cycle after reset release.
  - No combinational path exists from m_axis_tready to s_axis_tready.
- Read handshake: the head beat is presented whenever readable. m_axis_tvalid && m_axis_tready on an edge increments rd_ptr.
- m_axis_tvalid never drops without a handshake, and m_axis payload is stable while tvalid=1 && tready=0.
- Latency: a beat written at edge N is visible on m_axis at the cycle following edge N (1 cycle, empty-FIFO case).
- Simultaneous read and write in the same edge:
  - occupancy is unchanged
  - when empty, the write lands and the read cannot occur, since tvalid was 0
  - when full, the write cannot occur, since tready was 0.
- occupancy is a registered value: wr_ptr minus rd_ptr.
- m_axis payload is driven from a combinational read of the storage at rd_ptr (distributed-RAM style).

Optional Feature:
AXIS_FIFO_STORE_AND_FORWARD_EN.
- Without the macro: commit_ptr is not implemented, and m_axis_tvalid = not empty (cut-through).
- With the macro:
  - commit_ptr advances to wr_ptr+1 on each accepted beat with s_axis_tlast=1.
  - m_axis_tvalid = (rd_ptr != commit_ptr), so a packet is released only once its tlast beat is stored.
  - Oversize rule: if the FIFO is full and rd_ptr == commit_ptr (a packet longer than DEPTH), commit_ptr is forced to wr_ptr and the data cuts through. This avoids deadlock.
  - occupancy semantics are unchanged.

Decomposition:
- Package axis_pkg:
  - function axis_ptr_width(depth) returning $clog2(depth)+1
  - localparam helpers for the beat width: DATA_WIDTH*8 + DATA_WIDTH + USER_WIDTH + 1
  - field-offset constants for packing and unpacking the beat vector.
- Sub-module axis_fifo_mem: simple dual-port storage with one synchronous write port and one asynchronous read port, parametrised by entry width and DEPTH.

Test Plan:
- Reset, then check: s_axis_tready=1 one cycle after release, m_axis_tvalid=0, occupancy=0.
- DEPTH=16, DATA_WIDTH=4: write 16 beats 0x00000001..0x00000010 with m_axis_tready=0.
  - Expect occupancy=16 and s_axis_tready=0.
  - Then read all 16; data, tkeep and tlast come out in order and occupancy returns to 0.
- Empty FIFO: write a single beat 0xDEADBEEF, tkeep=0xF, tuser=1, tlast=1.
  - Expect m_axis_tvalid=1 exactly one cycle later with identical fields.
- Random s_axis_tvalid and m_axis_tready (50% each), 1000 beats with tkeep/tuser patterns:
  - scoreboard shows no loss, duplication or reorder
  - m_axis payload is stable while stalled
  - occupancy matches the model every cycle.
- Store-and-forward build: send a 5-beat packet with a 3-cycle gap before tlast.
  - Expect m_axis_tvalid=0 until the cycle after tlast is accepted, then 5 back-to-back beats.
  - Then send a 20-beat packet at DEPTH=16: expect the forced release at occupancy=16, with all 20 beats delivered.
- Assert aresetn for 1 cycle after 3 of 8 beats are written.
  - Expect occupancy=0 and m_axis_tvalid=0 immediately.
  - A following fresh 2-beat packet is delivered alone.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream FIFO: pointer sizing and the beat vector layout.
// Beat layout, LSB first: tlast, tuser, tkeep, tdata.
package axis_pkg;

    localparam int AXIS_LAST_LSB = 0;
    localparam int AXIS_USER_LSB = 1;

    function automatic int axis_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int axis_beat_width(input int data_bytes, input int user_bits);
        return data_bytes * 8 + data_bytes + user_bits + 1;
    endfunction

    function automatic int axis_keep_lsb(input int user_bits);
        return AXIS_USER_LSB + user_bits;
    endfunction

    function automatic int axis_data_lsb(input int data_bytes, input int user_bits);
        return axis_keep_lsb(user_bits) + data_bytes;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port beat storage: synchronous write, asynchronous read (distributed-RAM style).
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // No reset on the array: contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO carrying tdata/tkeep/tuser/tlast with occupancy output.
// Define AXIS_FIFO_STORE_AND_FORWARD_EN to hold each packet until its tlast beat is stored.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16
) (
    input  logic                       clock,
    input  logic                       aresetn,
    input  logic [DATA_WIDTH*8-1:0]    s_axis_tdata,
    input  logic [DATA_WIDTH-1:0]      s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH*8-1:0]    m_axis_tdata,
    output logic [DATA_WIDTH-1:0]      m_axis_tkeep,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = axis_ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int BW = axis_beat_width(DATA_WIDTH, USER_WIDTH);
    localparam int KL = axis_keep_lsb(USER_WIDTH);
    localparam int DL = axis_data_lsb(DATA_WIDTH, USER_WIDTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          s_ready_q, s_ready_d;
    logic          wr_en, rd_en;
    logic [BW-1:0] wr_beat, rd_beat;

    assign wr_en   = s_axis_tvalid && s_ready_q;
    assign rd_en   = m_axis_tvalid && m_axis_tready;
    assign wr_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

    // Ready is registered from next-state occupancy, so the sink's tready never
    // reaches s_axis_tready combinationally.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(wr_en);
        rd_ptr_d  = rd_ptr_q + PW'(rd_en);
        occ_d     = OW'(wr_ptr_d - rd_ptr_d);
        s_ready_d = occ_d < OW'(DEPTH);
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef AXIS_FIFO_STORE_AND_FORWARD_EN
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic          full;

    assign full = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A packet longer than the FIFO can never see its tlast stored; once full with
    // nothing committed, release what is stored so the writer can make progress.
    always_comb begin
        commit_ptr_d = commit_ptr_q;
        if (wr_en && s_axis_tlast)
            commit_ptr_d = wr_ptr_q + PW'(1);
        else if (full && (rd_ptr_q == commit_ptr_q))
            commit_ptr_d = wr_ptr_q;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) commit_ptr_q <= '0;
        else          commit_ptr_q <= commit_ptr_d;
    end

    assign m_axis_tvalid = rd_ptr_q != commit_ptr_q;
`else
    assign m_axis_tvalid = rd_ptr_q != wr_ptr_q;
`endif

    axis_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_beat),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_beat)
    );

    assign m_axis_tlast  = rd_beat[AXIS_LAST_LSB];
    assign m_axis_tuser  = rd_beat[AXIS_USER_LSB +: USER_WIDTH];
    assign m_axis_tkeep  = rd_beat[KL +: DATA_WIDTH];
    assign m_axis_tdata  = rd_beat[DL +: DATA_WIDTH*8];
    assign s_axis_tready = s_ready_q;
    assign occupancy     = occ_q;

endmodule
